paddle_shape_mapper: RTL and testbench

Pipelined, parametrised successor to the single-paddle pixel test. It evaluates N paddles per pixel, and each paddle is independently a rectangle or an ellipse with separate X/Y radii. Paddle geometry is double-buffered and taken up only on a frame-start pulse, so a paddle never tears mid-frame. The block sits between the VGA controller's DrawX/DrawY stream and the colour mapper, and returns a hit flag, the winning paddle index and a per-paddle hit mask.

---
 rtl/paddle_shape_mapper_if.sv | 33 +++
 rtl/paddle_shape_mapper.sv | 164 ++++++++++++++++
 tb/tb_paddle_shape_mapper.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/paddle_shape_mapper_if.sv
// paddle_shape_mapper_if: geometry, pixel-in and result-out signals of the paddle mapper
interface paddle_shape_mapper_if #(
  parameter int N_PADDLES = 2,
  parameter int COORD_W = 10,
  parameter int ID_W = 3
);
  logic frame_start;
  logic [N_PADDLES*COORD_W-1:0] pos_x;
  logic [N_PADDLES*COORD_W-1:0] pos_y;
  logic [N_PADDLES*COORD_W-1:0] rad_x;
  logic [N_PADDLES*COORD_W-1:0] rad_y;
  logic [N_PADDLES-1:0] shape_ellipse;
  logic [N_PADDLES-1:0] paddle_en;
  logic pix_valid_in;
  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic pix_valid_out;
  logic [COORD_W-1:0] DrawX_out;
  logic [COORD_W-1:0] DrawY_out;
  logic paddle_on;
  logic [ID_W-1:0] paddle_id;
  logic [N_PADDLES-1:0] hit_mask;
  modport master (
    output frame_start, pos_x, pos_y, rad_x, rad_y, shape_ellipse, paddle_en,
    output pix_valid_in, DrawX, DrawY,
    input pix_valid_out, DrawX_out, DrawY_out, paddle_on, paddle_id, hit_mask
  );
  modport slave (
    input frame_start, pos_x, pos_y, rad_x, rad_y, shape_ellipse, paddle_en,
    input pix_valid_in, DrawX, DrawY,
    output pix_valid_out, DrawX_out, DrawY_out, paddle_on, paddle_id, hit_mask
  );
endinterface

// File: rtl/paddle_shape_mapper.sv
// paddle_shape_mapper: 3-stage per-pixel hit test against N double-buffered rectangle/ellipse paddles
module paddle_shape_mapper #(
  parameter int N_PADDLES = 2,
  parameter int COORD_W = 10,
  parameter int ID_W = 3
) (
  input logic Clk,
  input logic Reset_n,
  paddle_shape_mapper_if.slave bus
);
  localparam int PW = 4*COORD_W+2;
  logic [COORD_W-1:0] sh_px [N_PADDLES];
  logic [COORD_W-1:0] sh_py [N_PADDLES];
  logic [COORD_W-1:0] sh_rx [N_PADDLES];
  logic [COORD_W-1:0] sh_ry [N_PADDLES];
  logic [N_PADDLES-1:0] sh_ell, sh_en;
  logic signed [COORD_W:0] dx_n [N_PADDLES];
  logic signed [COORD_W:0] dy_n [N_PADDLES];
  logic [COORD_W-1:0] adx_n [N_PADDLES];
  logic [COORD_W-1:0] ady_n [N_PADDLES];
  logic v1;
  logic [COORD_W-1:0] x1, y1;
  logic [COORD_W-1:0] adx1 [N_PADDLES];
  logic [COORD_W-1:0] ady1 [N_PADDLES];
  logic [COORD_W-1:0] rx1 [N_PADDLES];
  logic [COORD_W-1:0] ry1 [N_PADDLES];
  logic [N_PADDLES-1:0] ell1, en1;
  logic [N_PADDLES-1:0] rect_n;
  logic [PW-1:0] a_n [N_PADDLES];
  logic [PW-1:0] b_n [N_PADDLES];
  logic [PW-1:0] c_n [N_PADDLES];
  logic v2;
  logic [COORD_W-1:0] x2, y2;
  logic [N_PADDLES-1:0] rect2, ell2, en2;
  logic [PW-1:0] a2 [N_PADDLES];
  logic [PW-1:0] b2 [N_PADDLES];
  logic [PW-1:0] c2 [N_PADDLES];
  logic [N_PADDLES-1:0] hit;
  logic [ID_W-1:0] id;

  // shadow geometry, taken up only on frame_start so a paddle never tears mid-frame
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      for (int i = 0; i < N_PADDLES; i++) begin
        sh_px[i] <= '0;
        sh_py[i] <= '0;
        sh_rx[i] <= '0;
        sh_ry[i] <= '0;
      end
      sh_ell <= '0;
      sh_en <= '0;
    end else if (bus.frame_start) begin
      for (int i = 0; i < N_PADDLES; i++) begin
        sh_px[i] <= bus.pos_x[i*COORD_W +: COORD_W];
        sh_py[i] <= bus.pos_y[i*COORD_W +: COORD_W];
        sh_rx[i] <= bus.rad_x[i*COORD_W +: COORD_W];
        sh_ry[i] <= bus.rad_y[i*COORD_W +: COORD_W];
      end
      sh_ell <= bus.shape_ellipse;
      sh_en <= bus.paddle_en;
    end

  // exact signed offsets from each centre (one extra bit, so no wrap near 0 or max) and their magnitudes
  always_comb
    for (int i = 0; i < N_PADDLES; i++) begin
      dx_n[i] = $signed({1'b0, bus.DrawX}) - $signed({1'b0, sh_px[i]});
      dy_n[i] = $signed({1'b0, bus.DrawY}) - $signed({1'b0, sh_py[i]});
      adx_n[i] = dx_n[i][COORD_W] ? COORD_W'(-dx_n[i]) : dx_n[i][COORD_W-1:0];
      ady_n[i] = dy_n[i][COORD_W] ? COORD_W'(-dy_n[i]) : dy_n[i][COORD_W-1:0];
    end

  // stage 1: offsets plus radii; a zero-radius ellipse degrades to the rectangle test
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      v1 <= 1'b0;
      x1 <= '0;
      y1 <= '0;
      for (int i = 0; i < N_PADDLES; i++) begin
        adx1[i] <= '0;
        ady1[i] <= '0;
        rx1[i] <= '0;
        ry1[i] <= '0;
      end
      ell1 <= '0;
      en1 <= '0;
    end else begin
      v1 <= bus.pix_valid_in;
      x1 <= bus.DrawX;
      y1 <= bus.DrawY;
      for (int i = 0; i < N_PADDLES; i++) begin
        adx1[i] <= adx_n[i];
        ady1[i] <= ady_n[i];
        rx1[i] <= sh_rx[i];
        ry1[i] <= sh_ry[i];
        ell1[i] <= sh_ell[i] && sh_rx[i] != '0 && sh_ry[i] != '0;
      end
      en1 <= sh_en;
    end

  // rectangle compare and full-width ellipse products A=dx^2*ry^2, B=dy^2*rx^2, C=rx^2*ry^2
  always_comb
    for (int i = 0; i < N_PADDLES; i++) begin
      rect_n[i] = adx1[i] <= rx1[i] && ady1[i] <= ry1[i];
      a_n[i] = PW'(adx1[i]) * PW'(adx1[i]) * PW'(ry1[i]) * PW'(ry1[i]);
      b_n[i] = PW'(ady1[i]) * PW'(ady1[i]) * PW'(rx1[i]) * PW'(rx1[i]);
      c_n[i] = PW'(rx1[i]) * PW'(rx1[i]) * PW'(ry1[i]) * PW'(ry1[i]);
    end

  // stage 2: register the per-paddle terms
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      v2 <= 1'b0;
      x2 <= '0;
      y2 <= '0;
      rect2 <= '0;
      ell2 <= '0;
      en2 <= '0;
      for (int i = 0; i < N_PADDLES; i++) begin
        a2[i] <= '0;
        b2[i] <= '0;
        c2[i] <= '0;
      end
    end else begin
      v2 <= v1;
      x2 <= x1;
      y2 <= y1;
      rect2 <= rect_n;
      ell2 <= ell1;
      en2 <= en1;
      for (int i = 0; i < N_PADDLES; i++) begin
        a2[i] <= a_n[i];
        b2[i] <= b_n[i];
        c2[i] <= c_n[i];
      end
    end

  // final hit per paddle (A+B widened by a bit) and lowest-index priority pick
  always_comb begin
    hit = '0;
    id = '0;
    for (int i = 0; i < N_PADDLES; i++)
      hit[i] = en2[i] && (ell2[i] ? ({1'b0, a2[i]} + {1'b0, b2[i]} <= {1'b0, c2[i]}) : rect2[i]);
    for (int i = N_PADDLES-1; i >= 0; i--)
      if (hit[i]) id = ID_W'(i);
  end

  // stage 3: results, forced to zero in bubbles
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      bus.pix_valid_out <= 1'b0;
      bus.DrawX_out <= '0;
      bus.DrawY_out <= '0;
      bus.paddle_on <= 1'b0;
      bus.paddle_id <= '0;
      bus.hit_mask <= '0;
    end else begin
      bus.pix_valid_out <= v2;
      bus.DrawX_out <= v2 ? x2 : '0;
      bus.DrawY_out <= v2 ? y2 : '0;
      bus.paddle_on <= v2 && |hit;
      bus.paddle_id <= v2 ? id : '0;
      bus.hit_mask <= v2 ? hit : '0;
    end
endmodule

// File: tb/tb_paddle_shape_mapper.sv
// tb_paddle_shape_mapper: directed and random pixel streams checked against an arithmetic paddle model
module tb_paddle_shape_mapper;
  localparam int N = 2;
  localparam int W = 10;
  localparam int IW = 3;
  localparam int CMAX = (1 << W) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  paddle_shape_mapper_if #(.N_PADDLES(N), .COORD_W(W), .ID_W(IW)) bus ();
  paddle_shape_mapper #(.N_PADDLES(N), .COORD_W(W), .ID_W(IW)) dut (.Clk(clk), .Reset_n(rst_n), .bus(bus));

  typedef struct {
    int v;
    int x;
    int y;
    int on;
    int id;
    int mask;
  } res_t;

  res_t zero_r = '{default: 0};
  res_t q[$];
  int m_px[N], m_py[N], m_rx[N], m_ry[N], m_ell[N], m_en[N];
  int cur_px[N], cur_py[N];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic res_t model(input int v, input int x, input int y);
    res_t r;
    r = '{default: 0};
    if (v == 0) return r;
    r.v = 1;
    r.x = x;
    r.y = y;
    for (int i = N-1; i >= 0; i--) begin
      longint dx, dy, rx, ry;
      int h;
      dx = x - m_px[i];
      dy = y - m_py[i];
      rx = m_rx[i];
      ry = m_ry[i];
      if (m_en[i] == 0) h = 0;
      else if (m_ell[i] != 0 && rx > 0 && ry > 0) h = (dx*dx*ry*ry + dy*dy*rx*rx <= rx*rx*ry*ry) ? 1 : 0;
      else h = (dx <= rx && -dx <= rx && dy <= ry && -dy <= ry) ? 1 : 0;
      if (h != 0) begin
        r.mask |= 1 << i;
        r.on = 1;
        r.id = i;
      end
    end
    return r;
  endfunction

  task automatic set_paddle(input int i, input int px, input int py, input int rx, input int ry, input int ell, input int en);
    bus.pos_x[i*W +: W] = px[W-1:0];
    bus.pos_y[i*W +: W] = py[W-1:0];
    bus.rad_x[i*W +: W] = rx[W-1:0];
    bus.rad_y[i*W +: W] = ry[W-1:0];
    bus.shape_ellipse[i] = ell[0];
    bus.paddle_en[i] = en[0];
    cur_px[i] = px;
    cur_py[i] = py;
  endtask

  task automatic step(input int v, input int x, input int y, input int fs = 0);
    res_t e;
    @(negedge clk);
    e = q.pop_front();
    chk("valid", bus.pix_valid_out, e.v);
    chk("xout", bus.DrawX_out, e.x);
    chk("yout", bus.DrawY_out, e.y);
    chk("on", bus.paddle_on, e.on);
    chk("id", bus.paddle_id, e.id);
    chk("mask", bus.hit_mask, e.mask);
    bus.pix_valid_in = v[0];
    bus.DrawX = x[W-1:0];
    bus.DrawY = y[W-1:0];
    bus.frame_start = fs[0];
    q.push_back(model(v, x, y));
    if (fs != 0)
      for (int i = 0; i < N; i++) begin
        m_px[i] = int'(bus.pos_x[i*W +: W]);
        m_py[i] = int'(bus.pos_y[i*W +: W]);
        m_rx[i] = int'(bus.rad_x[i*W +: W]);
        m_ry[i] = int'(bus.rad_y[i*W +: W]);
        m_ell[i] = int'(bus.shape_ellipse[i]);
        m_en[i] = int'(bus.paddle_en[i]);
      end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.pix_valid_in = 1'b0;
    bus.frame_start = 1'b0;
    #1;
    chk("rst_valid", bus.pix_valid_out, 0);
    chk("rst_on", bus.paddle_on, 0);
    chk("rst_mask", bus.hit_mask, 0);
    chk("rst_id", bus.paddle_id, 0);
    chk("rst_xout", bus.DrawX_out, 0);
    for (int i = 0; i < N; i++) begin
      m_px[i] = 0;
      m_py[i] = 0;
      m_rx[i] = 0;
      m_ry[i] = 0;
      m_ell[i] = 0;
      m_en[i] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    q = '{zero_r, zero_r, zero_r};
  endtask

  function automatic int clampc(input int c);
    return c < 0 ? 0 : (c > CMAX ? CMAX : c);
  endfunction

  initial begin
    bus.frame_start = 1'b0;
    bus.pos_x = '0;
    bus.pos_y = '0;
    bus.rad_x = '0;
    bus.rad_y = '0;
    bus.shape_ellipse = '0;
    bus.paddle_en = '0;
    bus.pix_valid_in = 1'b0;
    bus.DrawX = '0;
    bus.DrawY = '0;
    do_reset();
    set_paddle(0, 100, 100, 10, 10, 0, 1);
    set_paddle(1, 0, 0, 5, 5, 0, 1);
    step(1, 100, 100);
    step(1, 0, 0);
    step(1, 639, 479);
    repeat (3) step(0, 0, 0);
    set_paddle(0, 50, 240, 8, 40, 0, 1);
    set_paddle(1, 600, 400, 4, 4, 0, 0);
    step(0, 0, 0, 1);
    step(1, 42, 200);
    step(1, 58, 280);
    step(1, 41, 240);
    step(1, 50, 281);
    set_paddle(1, 320, 240, 10, 20, 1, 1);
    step(0, 0, 0, 1);
    step(1, 330, 240);
    step(1, 320, 260);
    step(1, 331, 240);
    step(1, 327, 255);
    step(0, 0, 0);
    set_paddle(0, 100, 100, 5, 5, 0, 1);
    set_paddle(1, 102, 98, 5, 5, 0, 1);
    step(0, 0, 0, 1);
    step(1, 100, 100);
    set_paddle(0, 200, 200, 5, 5, 0, 1);
    step(1, 100, 100);
    step(1, 100, 100, 1);
    step(1, 100, 100);
    step(1, 200, 200);
    set_paddle(0, 300, 300, 5, 5, 0, 1);
    step(0, 0, 0, 1);
    step(1, 300, 300);
    step(1, 301, 302);
    step(1, 299, 298);
    do_reset();
    step(1, 300, 300);
    step(1, 300, 300);
    repeat (3) step(0, 0, 0);
    set_paddle(0, 400, 200, 0, 5, 1, 1);
    set_paddle(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(1, 400, 205);
    step(1, 401, 200);
    step(1, 400, 206);
    step(1, 400, 195);
    set_paddle(0, 3, 2, 6, 5, 1, 1);
    set_paddle(1, CMAX-2, CMAX-1, 7, 9, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0);
    step(1, CMAX-3, 4);
    step(1, CMAX, CMAX);
    step(1, 2, CMAX-1);
    for (int c = 0; c < 500; c++) begin
      int fs, p;
      if ($urandom_range(0, 19) == 0)
        for (int i = 0; i < N; i++)
          set_paddle(i, $urandom_range(0, CMAX), $urandom_range(0, CMAX), $urandom_range(0, 40),
                     $urandom_range(0, 40), $urandom_range(0, 1), $urandom_range(0, 3) != 0);
      fs = $urandom_range(0, 15) == 0;
      p = $urandom_range(0, N-1);
      step($urandom_range(0, 4) != 0, clampc(cur_px[p] + $urandom_range(0, 90) - 45),
           clampc(cur_py[p] + $urandom_range(0, 90) - 45), fs);
    end
    repeat (4) step(0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
